apb_gpio_irq: RTL and testbench

Parametrised APB general-purpose I/O controller, the successor to the current 8-bit GPIO port. It adds configurable width, an input synchroniser and a per-pin debounce filter, and per-pin edge/level interrupts with sticky flags. Set/clear/toggle alias registers provide atomic updates. It sits on the peripheral APB bus and drives the chip I/O pads, with a single interrupt line to the interrupt controller.

---
 rtl/apb_gpio_irq_if.sv | 23 ++
 rtl/apb_gpio_irq.sv | 161 ++++++++++++++++
 tb/tb_apb_gpio_irq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_irq_if.sv
// APB bus bundle for the GPIO controller.
// Handshake: a transfer is a setup phase (psel=1, penable=0) followed by an
// access phase (psel=1, penable=1); the slave is zero-wait (pready=1), so a
// write commits on the rising edge that sees psel & penable & pwrite.
interface apb_gpio_irq_if;
  logic        apbi_psel;
  logic        apbi_penable;
  logic        apbi_pwrite;
  logic [7:0]  apbi_paddr;
  logic [31:0] apbi_pwdata;
  logic [31:0] apbo_prdata;
  logic        apbo_pready;

  modport master (
    output apbi_psel, apbi_penable, apbi_pwrite, apbi_paddr, apbi_pwdata,
    input  apbo_prdata, apbo_pready
  );

  modport slave (
    input  apbi_psel, apbi_penable, apbi_pwrite, apbi_paddr, apbi_pwdata,
    output apbo_prdata, apbo_pready
  );
endinterface

// File: rtl/apb_gpio_irq.sv
// APB GPIO controller: synchronised and debounced inputs, OUT/DIR pad
// control with set/clear/toggle aliases, per-pin edge/level interrupts
// with sticky write-1-to-clear flags and a single registered irq line.
module apb_gpio_irq #(
  parameter int NBITS       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  apb_gpio_irq_if.slave    apb,
  input  logic [NBITS-1:0] gpioi_din,
  output logic [NBITS-1:0] gpioo_dout,
  output logic [NBITS-1:0] gpioo_oe,
  output logic             apbo_irq
);

  // Register state
  logic [NBITS-1:0]     out_q, out_d;
  logic [NBITS-1:0]     dir_q, dir_d;
  logic [NBITS-1:0]     imask_q, imask_d;
  logic [NBITS-1:0]     ipol_q, ipol_d;
  logic [NBITS-1:0]     iedge_q, iedge_d;
  logic [NBITS-1:0]     iflag_q, iflag_d;
  logic [DEB_WIDTH-1:0] deb_q, deb_d;
  logic                 irq_q;

  // Input path state
  logic [NBITS-1:0]     sync_q [SYNC_STAGES];
  logic [NBITS-1:0]     stable_q, stable_d;
  logic [NBITS-1:0]     stable_prev_q;
  logic [DEB_WIDTH-1:0] cnt_q [NBITS];
  logic [DEB_WIDTH-1:0] cnt_d [NBITS];

  logic [NBITS-1:0]     sync_s;
  logic [DEB_WIDTH:0]   teff;
  logic                 wr_en;
  logic [5:0]           widx;
  logic [NBITS-1:0]     wd;
  logic [NBITS-1:0]     w1c;
  logic [NBITS-1:0]     flag_set;
  logic [31:0]          rdata;
  logic                 unused_bits;

  assign wr_en       = apb.apbi_psel & apb.apbi_penable & apb.apbi_pwrite;
  assign widx        = apb.apbi_paddr[7:2];
  assign wd          = apb.apbi_pwdata[NBITS-1:0];
  assign sync_s      = sync_q[SYNC_STAGES-1];
  // A threshold of 0 behaves like 1 so a pin can never get stuck.
  assign teff        = (deb_q == '0) ? (DEB_WIDTH+1)'(1) : {1'b0, deb_q};
  assign unused_bits = ^{apb.apbi_paddr[1:0], apb.apbi_pwdata};

  // Per-pin debounce: count cycles that sync disagrees with stable; adopt sync at Teff.
  always_comb begin
    for (int p = 0; p < NBITS; p++) begin
      stable_d[p] = stable_q[p];
      cnt_d[p]    = '0;
      if (sync_s[p] != stable_q[p]) begin
        if (({1'b0, cnt_q[p]} + (DEB_WIDTH+1)'(1)) >= teff) begin
          stable_d[p] = sync_s[p];
        end else begin
          cnt_d[p] = cnt_q[p] + DEB_WIDTH'(1);
        end
      end
    end
  end

  // Flag sources: edges of the debounced value toward IPOL, or level equal to IPOL.
  assign flag_set = (iedge_q & (stable_q ^ stable_prev_q) & ~(stable_q ^ ipol_q))
                  | (~iedge_q & ~(stable_q ^ ipol_q));

  // Register writes, including the OR/AND/XOR alias views; set beats W1C.
  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    imask_d = imask_q;
    ipol_d  = ipol_q;
    iedge_d = iedge_q;
    deb_d   = deb_q;
    w1c     = '0;
    if (wr_en) begin
      case (widx)
        6'd1:  out_d   = wd;
        6'd2:  dir_d   = wd;
        6'd3:  imask_d = wd;
        6'd4:  ipol_d  = wd;
        6'd5:  iedge_d = wd;
        6'd6:  w1c     = wd;
        6'd7:  deb_d   = apb.apbi_pwdata[DEB_WIDTH-1:0];
        6'd21: out_d   = out_q | wd;
        6'd22: dir_d   = dir_q | wd;
        6'd23: imask_d = imask_q | wd;
        6'd25: out_d   = out_q & wd;
        6'd26: dir_d   = dir_q & wd;
        6'd27: imask_d = imask_q & wd;
        6'd29: out_d   = out_q ^ wd;
        6'd30: dir_d   = dir_q ^ wd;
        6'd31: imask_d = imask_q ^ wd;
        default: ;
      endcase
    end
    iflag_d = (iflag_q & ~w1c) | flag_set;
  end

  // Read mux: aliases read back their target register; 0 when unselected.
  always_comb begin
    rdata = '0;
    if (apb.apbi_psel) begin
      case (widx)
        6'd0:                      rdata[NBITS-1:0]     = stable_q;
        6'd1, 6'd21, 6'd25, 6'd29: rdata[NBITS-1:0]     = out_q;
        6'd2, 6'd22, 6'd26, 6'd30: rdata[NBITS-1:0]     = dir_q;
        6'd3, 6'd23, 6'd27, 6'd31: rdata[NBITS-1:0]     = imask_q;
        6'd4:                      rdata[NBITS-1:0]     = ipol_q;
        6'd5:                      rdata[NBITS-1:0]     = iedge_q;
        6'd6:                      rdata[NBITS-1:0]     = iflag_q;
        6'd7:                      rdata[DEB_WIDTH-1:0] = deb_q;
        default: ;
      endcase
    end
  end

  // All sequential state, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q         <= '0;
      dir_q         <= '0;
      imask_q       <= '0;
      ipol_q        <= '0;
      iedge_q       <= '0;
      iflag_q       <= '0;
      deb_q         <= '0;
      irq_q         <= 1'b0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int p = 0; p < NBITS; p++) cnt_q[p] <= '0;
    end else begin
      out_q         <= out_d;
      dir_q         <= dir_d;
      imask_q       <= imask_d;
      ipol_q        <= ipol_d;
      iedge_q       <= iedge_d;
      iflag_q       <= iflag_d;
      deb_q         <= deb_d;
      irq_q         <= |(iflag_q & imask_q);
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      sync_q[0]     <= gpioi_din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int p = 0; p < NBITS; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign apb.apbo_prdata = rdata;
  assign apb.apbo_pready = 1'b1;
  assign gpioo_dout      = out_q;
  assign gpioo_oe        = dir_q;
  assign apbo_irq        = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq (NBITS=8, SYNC_STAGES=2, DEB_WIDTH=4).
// The pad model loops OUT back onto pins whose DIR bit is set.
module tb_apb_gpio_irq;

  logic       clk;
  logic       rstn;
  logic [7:0] drv;
  logic [7:0] din;
  logic [7:0] gpioo_dout;
  logic [7:0] gpioo_oe;
  logic       apbo_irq;
  logic [31:0] rv;
  int n_vec;
  int n_err;

  apb_gpio_irq_if bus ();

  apb_gpio_irq #(.NBITS(8), .SYNC_STAGES(2), .DEB_WIDTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .apb        (bus.slave),
    .gpioi_din  (din),
    .gpioo_dout (gpioo_dout),
    .gpioo_oe   (gpioo_oe),
    .apbo_irq   (apbo_irq)
  );

  assign din = (gpioo_dout & gpioo_oe) | (drv & ~gpioo_oe);

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Setup then access phase; commits on the posedge inside, returns at the following negedge.
  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    bus.apbi_psel    = 1'b1;
    bus.apbi_penable = 1'b0;
    bus.apbi_pwrite  = 1'b1;
    bus.apbi_paddr   = addr;
    bus.apbi_pwdata  = data;
    @(negedge clk);
    bus.apbi_penable = 1'b1;
    @(negedge clk);
    bus.apbi_psel    = 1'b0;
    bus.apbi_penable = 1'b0;
    bus.apbi_pwrite  = 1'b0;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    bus.apbi_psel    = 1'b1;
    bus.apbi_penable = 1'b1;
    bus.apbi_pwrite  = 1'b0;
    bus.apbi_paddr   = addr;
    #1;
    data = bus.apbo_prdata;
    bus.apbi_psel    = 1'b0;
    bus.apbi_penable = 1'b0;
  endtask

  initial begin
    logic [7:0] pad_vals [8];
    pad_vals = '{8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'h00};
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    drv   = 8'h00;
    bus.apbi_psel    = 1'b0;
    bus.apbi_penable = 1'b0;
    bus.apbi_pwrite  = 1'b0;
    bus.apbi_paddr   = 8'h00;
    bus.apbi_pwdata  = 32'h0;

    // Reset state
    cyc(2);
    chk("rst_dout", {24'h0, gpioo_dout}, 32'h0);
    chk("rst_oe", {24'h0, gpioo_oe}, 32'h0);
    chk("rst_irq", {31'h0, apbo_irq}, 32'h0);
    chk("rst_prdata_idle", bus.apbo_prdata, 32'h0);
    rstn = 1'b1;
    cyc(1);
    rd(8'h04, rv); chk("rst_out", rv, 32'h0);
    rd(8'h08, rv); chk("rst_dir", rv, 32'h0);
    rd(8'h1C, rv); chk("rst_deb", rv, 32'h0);

    // Atomic aliases
    wr(8'h04, 32'h35); chk("out_wr", {24'h0, gpioo_dout}, 32'h35);
    wr(8'h54, 32'h03); chk("out_or", {24'h0, gpioo_dout}, 32'h37);
    wr(8'h64, 32'hF0); chk("out_and", {24'h0, gpioo_dout}, 32'h30);
    wr(8'h74, 32'hFF); chk("out_xor", {24'h0, gpioo_dout}, 32'hCF);
    rd(8'h54, rv); chk("alias_rd", rv, 32'hCF);
    rd(8'h20, rv); chk("unmapped_rd", rv, 32'h0);
    wr(8'h20, 32'hFFFF_FFFF);
    rd(8'h04, rv); chk("unmapped_wr", rv, 32'hCF);
    wr(8'h58, 32'h0F); chk("dir_or", {24'h0, gpioo_oe}, 32'h0F);
    wr(8'h78, 32'hFF); chk("dir_xor", {24'h0, gpioo_oe}, 32'hF0);
    wr(8'h68, 32'h00); chk("dir_and", {24'h0, gpioo_oe}, 32'h00);

    // Output sweep
    wr(8'h08, 32'hFF);
    for (int i = 0; i < 256; i++) begin
      wr(8'h04, i);
      chk("out_sweep", {24'h0, gpioo_dout}, i);
    end
    wr(8'h08, 32'h00);
    wr(8'h04, 32'h00);
    cyc(4);

    // Input loopback with Teff=1: SYNC_STAGES+1 edges
    for (int i = 0; i < 8; i++) begin
      drv = pad_vals[i];
      cyc(3);
      rd(8'h00, rv); chk("pad_in", rv, {24'h0, pad_vals[i]});
    end
    drv = 8'h0F;
    cyc(2);
    rd(8'h00, rv); chk("pad_early", rv, 32'h0);
    cyc(1);
    rd(8'h00, rv); chk("pad_ontime", rv, 32'h0F);
    drv = 8'h00;
    cyc(4);

    // Debounce T=3
    wr(8'h1C, 32'h3);
    rd(8'h1C, rv); chk("deb_rd", rv, 32'h3);
    drv[0] = 1'b1;
    cyc(2);
    drv[0] = 1'b0;
    cyc(8);
    rd(8'h00, rv); chk("deb_glitch2", rv, 32'h0);
    drv[0] = 1'b1;
    cyc(3);
    drv[0] = 1'b0;
    cyc(1);
    rd(8'h00, rv); chk("deb_pulse3_early", rv, 32'h0);
    cyc(1);
    rd(8'h00, rv); chk("deb_pulse3", rv, 32'h1);
    cyc(8);
    rd(8'h00, rv); chk("deb_release", rv, 32'h0);
    wr(8'h1C, 32'h0);

    // Edge interrupt on pin 0
    wr(8'h14, 32'h01);
    wr(8'h10, 32'h01);
    wr(8'h18, 32'h01);
    wr(8'h0C, 32'h01);
    chk("edge_irq_idle", {31'h0, apbo_irq}, 32'h0);
    rd(8'h18, rv); chk("edge_flag_idle", rv & 32'h1, 32'h0);
    drv[0] = 1'b1;
    cyc(3);
    rd(8'h18, rv); chk("edge_flag_early", rv & 32'h1, 32'h0);
    cyc(1);
    rd(8'h18, rv); chk("edge_flag_set", rv & 32'h1, 32'h1);
    chk("edge_irq_lag", {31'h0, apbo_irq}, 32'h0);
    cyc(1);
    chk("edge_irq_set", {31'h0, apbo_irq}, 32'h1);
    wr(8'h18, 32'h01);
    rd(8'h18, rv); chk("edge_w1c", rv & 32'h1, 32'h0);
    cyc(1);
    chk("edge_irq_drop", {31'h0, apbo_irq}, 32'h0);
    drv[0] = 1'b0;
    cyc(6);
    rd(8'h18, rv); chk("edge_fall_noflag", rv & 32'h1, 32'h0);
    chk("edge_fall_noirq", {31'h0, apbo_irq}, 32'h0);

    // Level interrupt on pin 1, set wins over W1C
    wr(8'h14, 32'h00);
    wr(8'h0C, 32'h00);
    wr(8'h10, 32'h02);
    drv[1] = 1'b1;
    cyc(4);
    chk("lvl_irq_masked", {31'h0, apbo_irq}, 32'h0);
    rd(8'h18, rv); chk("lvl_flag", (rv >> 1) & 32'h1, 32'h1);
    wr(8'h18, 32'h02);
    rd(8'h18, rv); chk("lvl_set_wins", (rv >> 1) & 32'h1, 32'h1);
    chk("lvl_irq_masked2", {31'h0, apbo_irq}, 32'h0);
    drv[1] = 1'b0;
    cyc(4);
    wr(8'h18, 32'h02);
    rd(8'h18, rv); chk("lvl_cleared", (rv >> 1) & 32'h1, 32'h0);
    chk("lvl_irq_masked3", {31'h0, apbo_irq}, 32'h0);

    // Asynchronous reset during a debounce count with irq raised
    wr(8'h1C, 32'h5);
    wr(8'h04, 32'hAA);
    wr(8'h08, 32'h0F);
    wr(8'h10, 32'h00);
    wr(8'h0C, 32'h01);
    drv = 8'h80;
    cyc(4);
    chk("pre_rst_irq", {31'h0, apbo_irq}, 32'h1);
    chk("pre_rst_dout", {24'h0, gpioo_dout}, 32'hAA);
    chk("pre_rst_oe", {24'h0, gpioo_oe}, 32'h0F);
    #2 rstn = 1'b0;
    #1;
    chk("arst_dout", {24'h0, gpioo_dout}, 32'h0);
    chk("arst_oe", {24'h0, gpioo_oe}, 32'h0);
    chk("arst_irq", {31'h0, apbo_irq}, 32'h0);
    chk("arst_prdata", bus.apbo_prdata, 32'h0);
    cyc(2);
    rstn = 1'b1;
    rd(8'h04, rv); chk("post_out", rv, 32'h0);
    rd(8'h08, rv); chk("post_dir", rv, 32'h0);
    rd(8'h0C, rv); chk("post_imask", rv, 32'h0);
    rd(8'h1C, rv); chk("post_deb", rv, 32'h0);
    rd(8'h18, rv); chk("post_iflag", rv, 32'h0);
    rd(8'h00, rv); chk("post_data", rv, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
